// File: rtl/product_accumulator_pkg.sv
// Shared types and helpers for the product accumulator: FSM states, default widths
// and the overflow-aware adder function used by acc_adder.
package product_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int unsigned PROD_W_DEF = 8;
    localparam int unsigned ACC_W_DEF  = 16;
    localparam int unsigned SAT_W_MAX  = 64;

    typedef struct packed {
        logic [SAT_W_MAX-1:0] sum;
        logic                 ovf;
    } sat_res_t;

    // Operands arrive sign-extended to SAT_W_MAX, so the wide sum is exact; it overflowed
    // w bits exactly when the addend signs match and the w-bit sum sign differs.
    function automatic sat_res_t sat_add(input logic [SAT_W_MAX-1:0] a,
                                         input logic [SAT_W_MAX-1:0] b,
                                         input int unsigned          w);
        sat_res_t r;
        logic signed [SAT_W_MAX-1:0] hi;
        r.sum = a + b;
        hi    = $signed(r.sum) >>> (w - 1);
        r.ovf = (hi != '0) && (hi != '1);
        return r;
    endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Handshake bundle between product source, accumulator and result sink.
interface product_accumulator_if
    import product_accumulator_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_product;
    logic              clear;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    modport master (
        output in_valid, in_product, clear, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_product, clear, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/product_accumulator_acc_adder.sv
// Combinational accumulate step: sign-extend the product, add, flag overflow.
// Defining PRODUCT_ACCUMULATOR_SATURATE_EN clamps overflowed sums to the signed limits.
module acc_adder
    import product_accumulator_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);
    logic [SAT_W_MAX-1:0] a_ext;
    logic [SAT_W_MAX-1:0] p_ext;
    sat_res_t             r;
    logic                 unused_hi;

    assign a_ext     = {{(SAT_W_MAX-ACC_W){acc[ACC_W-1]}}, acc};
    assign p_ext     = {{(SAT_W_MAX-PROD_W){product[PROD_W-1]}}, product};
    assign r         = sat_add(a_ext, p_ext, ACC_W);
    assign ovf       = r.ovf;
    assign unused_hi = ^r.sum[SAT_W_MAX-1:ACC_W];

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    // The exact wide sum's sign picks the clamp direction.
    always_comb begin
        sum = r.sum[ACC_W-1:0];
        if (r.ovf) begin
            sum = r.sum[SAT_W_MAX-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign sum = r.sum[ACC_W-1:0];
`endif
endmodule

// File: rtl/product_accumulator.sv
// Sums frames of FRAME_LEN signed products and offers each frame sum on a registered
// valid/ready output; saturation is selected by PRODUCT_ACCUMULATOR_SATURATE_EN.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int unsigned PROD_W    = PROD_W_DEF,
    parameter int unsigned ACC_W     = ACC_W_DEF,
    parameter int unsigned FRAME_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    product_accumulator_if.slave bus
);
    localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf_this;
    logic             ovf_sticky;
    logic             in_xfer;
    logic             out_xfer;
    logic             last;

    assign bus.in_ready = (state == HOLD) ? bus.out_ready : !bus.clear;
    assign in_xfer      = bus.in_valid && bus.in_ready;
    assign out_xfer     = bus.out_valid && bus.out_ready;
    assign last         = (cnt == CNT_W'(FRAME_LEN - 1));

    acc_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc     (acc),
        .product (bus.in_product),
        .sum     (sum),
        .ovf     (ovf_this)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ACCUM;
            acc           <= '0;
            cnt           <= '0;
            ovf_sticky    <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_ovf   <= 1'b0;
        end else if (state == ACCUM && bus.clear) begin
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            // acc/ovf_sticky are already zero in HOLD, so a product accepted there starts a
            // fresh frame; a completion assigned later overrides the drain (FRAME_LEN==1).
            if (out_xfer) begin
                bus.out_valid <= 1'b0;
                state         <= ACCUM;
            end
            if (in_xfer) begin
                if (last) begin
                    bus.out_sum   <= sum;
                    bus.out_ovf   <= ovf_sticky | ovf_this;
                    bus.out_valid <= 1'b1;
                    acc           <= '0;
                    cnt           <= '0;
                    ovf_sticky    <= 1'b0;
                    state         <= HOLD;
                end else begin
                    acc        <= sum;
                    cnt        <= cnt + 1'b1;
                    ovf_sticky <= ovf_sticky | ovf_this;
                end
            end
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: three instances (default, ACC_W=8, FRAME_LEN=1)
// with per-instance expected-result queues checked on every output handshake.
module tb_product_accumulator;

    typedef struct packed {
        logic signed [31:0] sum;
        logic               ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    exp_t q0[$];
    exp_t q8[$];
    exp_t q1[$];

    logic signed [7:0] t1[4] = '{8'sd4, 8'sd9, 8'sd12, -8'sd12};
    logic signed [7:0] t3[4] = '{8'sd64, 8'sd64, 8'sd0, 8'sd0};
    logic signed [7:0] t4[4] = '{-8'sd64, -8'sd64, -8'sd64, 8'sd0};
    logic signed [7:0] t7[6] = '{8'sd5, -8'sd3, 8'sd127, -8'sd128, 8'sd0, 8'sd42};

    always #5 clk = ~clk;

    product_accumulator_if #(.PROD_W(8), .ACC_W(16)) b0 ();
    product_accumulator_if #(.PROD_W(8), .ACC_W(8))  b8 ();
    product_accumulator_if #(.PROD_W(8), .ACC_W(16)) b1 ();

    product_accumulator #(.PROD_W(8), .ACC_W(16), .FRAME_LEN(4)) u0 (.clk(clk), .rst(rst), .bus(b0));
    product_accumulator #(.PROD_W(8), .ACC_W(8),  .FRAME_LEN(4)) u8 (.clk(clk), .rst(rst), .bus(b8));
    product_accumulator #(.PROD_W(8), .ACC_W(16), .FRAME_LEN(1)) u1 (.clk(clk), .rst(rst), .bus(b1));

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pushq(input int sel, input int s, input logic o);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        if (sel == 0) q0.push_back(e);
        else if (sel == 8) q8.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic mon();
        exp_t e;
        if (b0.out_valid && b0.out_ready) begin
            chk("u0_expected", int'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("u0_sum", $signed(b0.out_sum), e.sum);
                chk("u0_ovf", b0.out_ovf, e.ovf);
            end
        end
        if (b8.out_valid && b8.out_ready) begin
            chk("u8_expected", int'(q8.size() != 0), 1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                chk("u8_sum", $signed(b8.out_sum), e.sum);
                chk("u8_ovf", b8.out_ovf, e.ovf);
            end
        end
        if (b1.out_valid && b1.out_ready) begin
            chk("u1_expected", int'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("u1_sum", $signed(b1.out_sum), e.sum);
                chk("u1_ovf", b1.out_ovf, e.ovf);
            end
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic signed [7:0] p);
        b0.in_product = p;
        b0.in_valid   = 1'b1;
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        b0.in_valid = 1'b0; b0.in_product = '0; b0.clear = 1'b0; b0.out_ready = 1'b1;
        b8.in_valid = 1'b0; b8.in_product = '0; b8.clear = 1'b0; b8.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.in_product = '0; b1.clear = 1'b0; b1.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_u0_valid", b0.out_valid, 0);
        chk("rst_u0_sum", $signed(b0.out_sum), 0);
        chk("rst_u0_ovf", b0.out_ovf, 0);
        chk("rst_u8_valid", b8.out_valid, 0);
        chk("rst_u1_valid", b1.out_valid, 0);
        rst = 1'b0;
        chk("rst_u0_in_ready", b0.in_ready, 1);

        // Basic frame, input held valid, sink always ready.
        for (int i = 0; i < 4; i++) begin
            b0.in_product = t1[i];
            b0.in_valid   = 1'b1;
            if (i == 3) pushq(0, 13, 1'b0);
            #1;
            chk("t1_in_ready", b0.in_ready, 1);
            chk("t1_no_early_valid", b0.out_valid, 0);
            cyc();
        end
        b0.in_valid = 1'b0;
        chk("t1_valid_latency", b0.out_valid, 1);
        cyc();
        chk("t1_valid_drop", b0.out_valid, 0);

        // Output stall: sum held stable, input back-pressured, no bubble on release.
        b0.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send0(8'sd64);
        pushq(0, 256, 1'b0);
        b0.in_product = 8'sd1;
        b0.in_valid   = 1'b1;
        repeat (5) begin
            #1;
            chk("t2_stall_in_ready", b0.in_ready, 0);
            chk("t2_stall_valid", b0.out_valid, 1);
            chk("t2_stall_sum", $signed(b0.out_sum), 256);
            cyc();
        end
        b0.out_ready = 1'b1;
        #1;
        chk("t2_release_in_ready", b0.in_ready, 1);
        cyc();
        pushq(0, 4, 1'b0);
        for (int i = 0; i < 3; i++) send0(8'sd1);
        b0.in_valid = 1'b0;
        cyc();

        // Narrow accumulator overflow, positive then negative.
        for (int i = 0; i < 4; i++) begin
            b8.in_product = t3[i];
            b8.in_valid   = 1'b1;
            cyc();
        end
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        pushq(8, 127, 1'b1);
`else
        pushq(8, -128, 1'b1);
`endif
        for (int i = 0; i < 4; i++) begin
            b8.in_product = t4[i];
            cyc();
        end
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        pushq(8, -128, 1'b1);
`else
        pushq(8, 64, 1'b1);
`endif
        b8.in_valid = 1'b0;
        cyc();

        // clear drops the partial frame and the product presented with it.
        send0(8'sd5);
        send0(8'sd7);
        b0.in_product = 8'sd3;
        b0.clear      = 1'b1;
        #1;
        chk("t5_clear_in_ready", b0.in_ready, 0);
        cyc();
        b0.clear = 1'b0;
        pushq(0, 10, 1'b0);
        send0(8'sd1);
        send0(8'sd2);
        send0(8'sd3);
        send0(8'sd4);
        b0.in_valid = 1'b0;
        cyc();

        // Reset during HOLD loses the pending output.
        b0.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send0(8'sd3);
        b0.in_valid = 1'b0;
        chk("t6_hold_pending", b0.out_valid, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_hold_rst_valid", b0.out_valid, 0);
        chk("t6_hold_rst_sum", $signed(b0.out_sum), 0);
        b0.out_ready = 1'b1;

        // Reset mid-frame discards the partial sum.
        send0(8'sd7);
        send0(8'sd7);
        b0.in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        pushq(0, 8, 1'b0);
        for (int i = 0; i < 4; i++) send0(8'sd2);
        b0.in_valid = 1'b0;
        repeat (3) cyc();

        // FRAME_LEN=1: one result per cycle, back to back.
        for (int i = 0; i < 6; i++) begin
            b1.in_product = t7[i];
            b1.in_valid   = 1'b1;
            pushq(1, int'(t7[i]), 1'b0);
            #1;
            chk("t7_in_ready", b1.in_ready, 1);
            cyc();
        end
        b1.in_valid = 1'b0;
        cyc();
        chk("t7_valid_drop", b1.out_valid, 0);

        chk("q0_drained", q0.size(), 0);
        chk("q8_drained", q8.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
